tsc_cond_gen: RTL

- Upstream condition generator for the AES trigger-state counter.
- Watches the AES plaintext load stream and drives two level signals, r1 and r2, into the trigger counter's r1/r2 inputs.
- r1 is a sticky "armed" flag, set once an ordered three-block plaintext sequence is seen.
- r2 is an activity window that stays high for a fixed number of cycles after each load.

---
 rtl/aes_tj_pkg.sv | 37 +++
 rtl/tsc_win_cnt.sv | 45 ++++
 rtl/tsc_cond_gen.sv | 107 ++++++++++
 3 files changed

// File: rtl/aes_tj_pkg.sv
// Shared types and constants for the AES trigger-state condition generator.
// Holds the sequence FSM state encoding, the default plaintext patterns,
// the window counter width and the sequence next-state helper.
package aes_tj_pkg;

   // Sequence-detector states; the encoding is visible on the debug port
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GOT0  = 2'd1,
      GOT1  = 2'd2,
      ARMED = 2'd3
   } seq_state_t;

   localparam int WINDOW_W = 8;

   localparam logic [127:0] PAT0_DEF = 128'h3243F6A8885A308D313198A2E0370734;
   localparam logic [127:0] PAT1_DEF = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] PAT2_DEF = 128'h0;

   // Next state on a load cycle. The pattern that advances the sequence is
   // tested before PAT0, so advancing wins over restarting when they overlap.
   function automatic seq_state_t seq_next(input seq_state_t cur,
                                           input logic       is_pat0,
                                           input logic       is_pat1,
                                           input logic       is_pat2);
      seq_state_t nxt;
      nxt = cur;
      case (cur)
         IDLE:    nxt = is_pat0 ? GOT0 : IDLE;
         GOT0:    nxt = is_pat1 ? GOT1 : (is_pat0 ? GOT0 : IDLE);
         GOT1:    nxt = is_pat2 ? ARMED : (is_pat0 ? GOT0 : IDLE);
         default: nxt = ARMED;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/tsc_win_cnt.sv
// Reloadable activity-window down-counter. Every load reloads the count to
// WINDOW; otherwise it decrements to zero and stops. active is registered
// together with the count, so it is high for exactly WINDOW cycles after a
// single load and never high when WINDOW is 0.
module tsc_win_cnt #(
   parameter int WINDOW   = 16,
   parameter int WINDOW_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic active
);

   localparam logic [WINDOW_W-1:0] RELOAD = WINDOW_W'(WINDOW);
   localparam logic [WINDOW_W-1:0] ONE    = WINDOW_W'(1);

   logic [WINDOW_W-1:0] cnt_q;
   logic [WINDOW_W-1:0] cnt_d;
   logic                active_q;

   // Next count: unconditional reload on load, else saturating decrement
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = RELOAD;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - ONE;
      end
   end

   // Count register and its registered nonzero flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         active_q <= (cnt_d != '0);
      end
   end

   assign active = active_q;

endmodule

// File: rtl/tsc_cond_gen.sv
// Condition generator feeding the AES trigger-state counter.
// r1: sticky armed flag, set once PAT0, PAT1, PAT2 are loaded in order.
// r2: activity window, high for WINDOW cycles after each load.
// Build option TSC_COND_TIMEOUT_EN: a partial match (GOT0/GOT1) that sees
// TIMEOUT consecutive load-free cycles falls back to IDLE.
module tsc_cond_gen
   import aes_tj_pkg::*;
#(
   parameter int                DATA_W  = 128,
   parameter logic [DATA_W-1:0] PAT0    = DATA_W'(PAT0_DEF),
   parameter logic [DATA_W-1:0] PAT1    = DATA_W'(PAT1_DEF),
   parameter logic [DATA_W-1:0] PAT2    = DATA_W'(PAT2_DEF),
   parameter int                WINDOW  = 16,
   parameter int                TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] data,
   output logic              r1,
   output logic              r2,
   output logic [1:0]        seq_state
);

   localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

   seq_state_t state_q;
   seq_state_t state_d;
   logic       r1_q;
   logic       is_pat0;
   logic       is_pat1;
   logic       is_pat2;
   logic       timeout_hit;

   // Full-width pattern compares, evaluated in the same cycle as the load
   always_comb begin
      is_pat0 = (data == PAT0);
      is_pat1 = (data == PAT1);
      is_pat2 = (data == PAT2);
   end

`ifdef TSC_COND_TIMEOUT_EN
   logic [7:0] idle_q;
   logic [7:0] idle_d;

   // Idle-cycle count while a partial match waits; expiry forces IDLE
   always_comb begin
      idle_d      = '0;
      timeout_hit = 1'b0;
      if (!load && (state_q == GOT0 || state_q == GOT1)) begin
         if (({1'b0, idle_q} + 9'd1) >= TIMEOUT_LIM) begin
            timeout_hit = 1'b1;
         end else begin
            idle_d = idle_q + 8'd1;
         end
      end
   end

   // Idle counter register
   always_ff @(posedge clk) begin
      if (!rst) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   // Partial matches never expire in this build; the limit only matters
   // if someone configures it out of range.
   assign timeout_hit = (TIMEOUT_LIM > 9'd255);
`endif

   // Next state: loads drive the sequence, a timeout only applies without a load
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = seq_next(state_q, is_pat0, is_pat1, is_pat2);
      end else if (timeout_hit && state_q != ARMED) begin
         state_d = IDLE;
      end
   end

   // Sequence FSM register with registered armed output
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         r1_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         r1_q    <= (state_d == ARMED);
      end
   end

   tsc_win_cnt #(
      .WINDOW   (WINDOW),
      .WINDOW_W (WINDOW_W)
   ) u_win_cnt (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .active (r2)
   );

   assign r1        = r1_q;
   assign seq_state = state_q;

endmodule
